// File: rtl/billiard_pkg.sv
// Shared types and fixed-point constants for the billiard ball datapath.
package billiard_pkg;

    // Position and velocity carry 6 fractional bits (1/64 pixel).
    localparam int unsigned FRAC_BITS = 6;
    localparam int unsigned POS_W     = 17;
    localparam int unsigned VEL_W     = 16;

    // Unsigned Q11.6 position, signed Q9.6 velocity.
    typedef logic        [POS_W-1:0] pos_q_t;
    typedef logic signed [VEL_W-1:0] vel_q_t;

    typedef enum logic [1:0] {
        AIM    = 2'd0,
        CHARGE = 2'd1,
        ROLL   = 2'd2
    } ball_state_t;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis frame update: integrate, cushion bounce, friction decay.
module ball_axis_step
    import billiard_pkg::*;
#(
    parameter int unsigned FRICTION_SHIFT = 6
) (
    input  pos_q_t p,
    input  vel_q_t v,
    input  pos_q_t p_min,
    input  pos_q_t p_max,
    output pos_q_t p_next,
    output vel_q_t v_next
);

    logic signed [POS_W:0] p_sum;
    vel_q_t                v_bounced;
    logic [VEL_W-1:0]      mag;
    logic [VEL_W-1:0]      dec;
    logic [VEL_W-1:0]      mag_next;

    // Integrate in 18-bit signed, clamp to the cushions, then decay the speed.
    always_comb begin
        p_sum     = $signed({1'b0, p}) + $signed({{(POS_W+1-VEL_W){v[VEL_W-1]}}, v});
        p_next    = p_sum[POS_W-1:0];
        v_bounced = v;

        if (p_sum < $signed({1'b0, p_min})) begin
            p_next    = p_min;
            v_bounced = -v;
        end else if (p_sum > $signed({1'b0, p_max})) begin
            p_next    = p_max;
            v_bounced = -v;
        end

        // Friction works on magnitude so both directions decay identically;
        // the +1 term guarantees the speed reaches zero.
        mag      = v_bounced[VEL_W-1] ? VEL_W'(-v_bounced) : VEL_W'(v_bounced);
        dec      = (mag >> FRICTION_SHIFT) + 16'd1;
        mag_next = (mag > dec) ? (mag - dec) : '0;

        v_next = vel_q_t'(mag_next);
        if (v_bounced[VEL_W-1]) begin
            v_next = -v_next;
        end
    end

endmodule

// File: rtl/white_ball_move.sv
// White ball motion: latches the cue vector on release, then rolls the
// ball once per frame until friction stops it.
module white_ball_move
    import billiard_pkg::*;
#(
    parameter int unsigned INITIAL_X      = 320,
    parameter int unsigned INITIAL_Y      = 240,
    parameter int unsigned X_MIN          = 32,
    parameter int unsigned X_MAX          = 592,
    parameter int unsigned Y_MIN          = 32,
    parameter int unsigned Y_MAX          = 432,
    parameter int unsigned FRICTION_SHIFT = 6
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        game_state,
    input  logic        space_pressed,
    input  logic        pocketed,
    input  logic [31:0] velocityX,
    input  logic [31:0] velocityY,
    output logic [10:0] whiteBallTopLeftX,
    output logic [10:0] whiteBallTopLeftY,
    output logic        ball_moving,
    output logic        shot_fired
);

    localparam pos_q_t INIT_X_Q = pos_q_t'(INITIAL_X << FRAC_BITS);
    localparam pos_q_t INIT_Y_Q = pos_q_t'(INITIAL_Y << FRAC_BITS);
    localparam pos_q_t X_MIN_Q  = pos_q_t'(X_MIN << FRAC_BITS);
    localparam pos_q_t X_MAX_Q  = pos_q_t'(X_MAX << FRAC_BITS);
    localparam pos_q_t Y_MIN_Q  = pos_q_t'(Y_MIN << FRAC_BITS);
    localparam pos_q_t Y_MAX_Q  = pos_q_t'(Y_MAX << FRAC_BITS);

    ball_state_t state_q, state_d;
    pos_q_t      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    vel_q_t      vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic        ball_moving_q, ball_moving_d;
    logic        shot_fired_q, shot_fired_d;

    pos_q_t      step_px, step_py;
    vel_q_t      step_vx, step_vy;
    vel_q_t      vel_in_x, vel_in_y;
    logic [31:0] vel_hi_unused;

    // Cue velocity is bounded to +/-510, so the low 16 bits carry it fully.
    assign vel_in_x      = vel_q_t'(velocityX[VEL_W-1:0]);
    assign vel_in_y      = vel_q_t'(velocityY[VEL_W-1:0]);
    assign vel_hi_unused = {velocityX[31:VEL_W], velocityY[31:VEL_W]};

    ball_axis_step #(
        .FRICTION_SHIFT(FRICTION_SHIFT)
    ) u_step_x (
        .p      (pos_x_q),
        .v      (vel_x_q),
        .p_min  (X_MIN_Q),
        .p_max  (X_MAX_Q),
        .p_next (step_px),
        .v_next (step_vx)
    );

    ball_axis_step #(
        .FRICTION_SHIFT(FRICTION_SHIFT)
    ) u_step_y (
        .p      (pos_y_q),
        .v      (vel_y_q),
        .p_min  (Y_MIN_Q),
        .p_max  (Y_MAX_Q),
        .p_next (step_py),
        .v_next (step_vy)
    );

    // Next-state, position/velocity update and pulse generation.
    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        vel_x_d      = vel_x_q;
        vel_y_d      = vel_y_q;
        shot_fired_d = 1'b0;

        if (!game_state) begin
            // Leaving play freezes the ball where it is.
            state_d = AIM;
            vel_x_d = '0;
            vel_y_d = '0;
        end else begin
            case (state_q)
                AIM: begin
                    if (space_pressed) begin
                        state_d = CHARGE;
                    end
                end
                CHARGE: begin
                    if (startOfFrame && !space_pressed) begin
                        if (vel_in_x == '0 && vel_in_y == '0) begin
                            state_d = AIM;
                        end else begin
                            state_d      = ROLL;
                            vel_x_d      = vel_in_x;
                            vel_y_d      = vel_in_y;
                            shot_fired_d = 1'b1;
                        end
                    end
                end
                ROLL: begin
                    if (pocketed) begin
                        state_d = AIM;
                        pos_x_d = INIT_X_Q;
                        pos_y_d = INIT_Y_Q;
                        vel_x_d = '0;
                        vel_y_d = '0;
                    end else if (startOfFrame) begin
                        pos_x_d = step_px;
                        pos_y_d = step_py;
                        vel_x_d = step_vx;
                        vel_y_d = step_vy;
                        if (step_vx == '0 && step_vy == '0) begin
                            state_d = AIM;
                        end
                    end
                end
                default: state_d = AIM;
            endcase
        end

        ball_moving_d = (state_d == ROLL);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= AIM;
            pos_x_q       <= INIT_X_Q;
            pos_y_q       <= INIT_Y_Q;
            vel_x_q       <= '0;
            vel_y_q       <= '0;
            ball_moving_q <= 1'b0;
            shot_fired_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            vel_x_q       <= vel_x_d;
            vel_y_q       <= vel_y_d;
            ball_moving_q <= ball_moving_d;
            shot_fired_q  <= shot_fired_d;
        end
    end

    assign whiteBallTopLeftX = pos_x_q[POS_W-1:FRAC_BITS];
    assign whiteBallTopLeftY = pos_y_q[POS_W-1:FRAC_BITS];
    assign ball_moving       = ball_moving_q;
    assign shot_fired        = shot_fired_q;

endmodule

// File: tb/tb_white_ball_move.sv
// Bench for white_ball_move: integer reference model of the ball physics,
// randomized shots, cushion, pocket and reset scenarios.
`timescale 1ns/1ps
module tb_white_ball_move;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        game_state;
    logic        space_pressed;
    logic        pocketed;
    logic [31:0] velocityX;
    logic [31:0] velocityY;
    logic [10:0] whiteBallTopLeftX, whiteBallTopLeftY;
    logic        ball_moving, shot_fired;
    logic [10:0] x2, y2;
    logic        mv2, sf2;

    int total = 0;
    int bad   = 0;
    int shot_cnt = 0;

    // Reference model: mode 0 = waiting, 1 = cue drawn back, 2 = rolling.
    int m_mode, m_px, m_py, m_vx, m_vy, m_moving, m_shot;

    white_ball_move dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .game_state        (game_state),
        .space_pressed     (space_pressed),
        .pocketed          (pocketed),
        .velocityX         (velocityX),
        .velocityY         (velocityY),
        .whiteBallTopLeftX (whiteBallTopLeftX),
        .whiteBallTopLeftY (whiteBallTopLeftY),
        .ball_moving       (ball_moving),
        .shot_fired        (shot_fired)
    );

    // Second instance spawned next to the right cushion.
    white_ball_move #(
        .INITIAL_X (590)
    ) dut_r (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .game_state        (game_state),
        .space_pressed     (space_pressed),
        .pocketed          (pocketed),
        .velocityX         (velocityX),
        .velocityY         (velocityY),
        .whiteBallTopLeftX (x2),
        .whiteBallTopLeftY (y2),
        .ball_moving       (mv2),
        .shot_fired        (sf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (shot_fired) shot_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = 0; m_px = 320 * 64; m_py = 240 * 64;
        m_vx = 0; m_vy = 0; m_moving = 0; m_shot = 0;
    endtask

    task automatic axis_model(inout int p, inout int v, input int lo, input int hi);
        int m;
        p = p + v;
        if (p < lo * 64) begin
            p = lo * 64; v = -v;
        end else if (p > hi * 64) begin
            p = hi * 64; v = -v;
        end
        m = (v < 0) ? -v : v;
        m = m - (m / 64 + 1);
        if (m < 0) m = 0;
        v = (v < 0) ? -m : m;
    endtask

    task automatic model_clk();
        int lx, ly;
        m_shot = 0;
        if (!resetN) begin
            model_reset();
            return;
        end
        if (!game_state) begin
            m_mode = 0; m_vx = 0; m_vy = 0;
        end else if (m_mode == 0) begin
            if (space_pressed) m_mode = 1;
        end else if (m_mode == 1) begin
            if (startOfFrame && !space_pressed) begin
                lx = int'($signed(velocityX[15:0]));
                ly = int'($signed(velocityY[15:0]));
                if (lx == 0 && ly == 0) m_mode = 0;
                else begin
                    m_vx = lx; m_vy = ly; m_mode = 2; m_shot = 1;
                end
            end
        end else begin
            if (pocketed) begin
                m_px = 320 * 64; m_py = 240 * 64; m_vx = 0; m_vy = 0; m_mode = 0;
            end else if (startOfFrame) begin
                axis_model(m_px, m_vx, 32, 592);
                axis_model(m_py, m_vy, 32, 432);
                if (m_vx == 0 && m_vy == 0) m_mode = 0;
            end
        end
        m_moving = (m_mode == 2) ? 1 : 0;
    endtask

    // One clock: model sees the same inputs as the DUT; outputs settle by #1.
    task automatic tick();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic frame(input int period);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (period - 1) tick();
    endtask

    // Hold the key for two frames, then release it on a frame strobe.
    task automatic launch(input int vx, input int vy);
        game_state = 1'b1; space_pressed = 1'b1;
        frame(4);
        frame(4);
        space_pressed = 1'b0;
        velocityX = 32'(vx); velocityY = 32'(vy);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        startOfFrame = 0; space_pressed = 0; pocketed = 0; game_state = 1;
        velocityX = '0; velocityY = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        startOfFrame = 0; space_pressed = 0; pocketed = 0; game_state = 0;
        velocityX = '0; velocityY = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, shot_fired} !== {11'd320, 11'd240, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got x=%0d y=%0d mv=%0b sf=%0b, want 320 240 0 0",
                     whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, shot_fired);
        end
        resetN = 1'b1;
        game_state = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame(4);
            total++;
            if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving} !== {11'd320, 11'd240, 1'b0} || shot_cnt != 0) begin
                bad++;
                $display("FAIL idle_frame%0d: got x=%0d y=%0d mv=%0b shots=%0d, want 320 240 0 0",
                         f, whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, shot_cnt);
            end
        end
    endtask

    task automatic test_shot_x();
        int shots0;
        apply_reset();
        shots0 = shot_cnt;
        launch(510, 0);
        total++;
        if (shot_fired !== 1'b1 || ball_moving !== 1'b1) begin
            bad++;
            $display("FAIL launch_pulse: got sf=%0b mv=%0b, want 1 1", shot_fired, ball_moving);
        end
        frame(4);
        total++;
        if (whiteBallTopLeftX !== 11'd327 || whiteBallTopLeftY !== 11'd240 || shot_cnt - shots0 != 1) begin
            bad++;
            $display("FAIL first_roll_frame: got x=%0d y=%0d shots=%0d, want 327 240 1",
                     whiteBallTopLeftX, whiteBallTopLeftY, shot_cnt - shots0);
        end
        frame(4);
        total++;
        if (whiteBallTopLeftX !== 11'd335) begin
            bad++;
            $display("FAIL second_roll_frame: got x=%0d, want 335", whiteBallTopLeftX);
        end
    endtask

    task automatic test_stop();
        int frames = 2;
        while (ball_moving === 1'b1 && frames < 600) begin
            frame(4);
            frames++;
            total++;
            if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving} !== {11'(m_px / 64), 11'(m_py / 64), m_moving[0]}) begin
                bad++;
                $display("FAIL stop_track f%0d: got x=%0d y=%0d mv=%0b, want %0d %0d %0d",
                         frames, whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, m_px / 64, m_py / 64, m_moving);
            end
        end
        total++;
        if (frames > 512 || ball_moving !== 1'b0) begin
            bad++;
            $display("FAIL stop_bound: got frames=%0d mv=%0b, want <=512 0", frames, ball_moving);
        end
        for (int f = 0; f < 5; f++) begin
            frame(4);
            total++;
            if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving} !== {11'(m_px / 64), 11'(m_py / 64), 1'b0}) begin
                bad++;
                $display("FAIL stopped_hold%0d: got x=%0d y=%0d, want %0d %0d",
                         f, whiteBallTopLeftX, whiteBallTopLeftY, m_px / 64, m_py / 64);
            end
        end
    endtask

    task automatic test_right_cushion();
        apply_reset();
        launch(256, 0);
        frame(4);
        total++;
        if (x2 !== 11'd592 || mv2 !== 1'b1) begin
            bad++;
            $display("FAIL cushion_clamp: got x=%0d mv=%0b, want 592 1", x2, mv2);
        end
        frame(4);
        total++;
        if (x2 !== 11'd588) begin
            bad++;
            $display("FAIL cushion_rebound: got x=%0d, want 588", x2);
        end
        total++;
        if (whiteBallTopLeftX !== 11'(m_px / 64)) begin
            bad++;
            $display("FAIL cushion_main: got x=%0d, want %0d", whiteBallTopLeftX, m_px / 64);
        end
    endtask

    task automatic test_diagonal();
        int prev_x, prev_y, bx, by, guard;
        apply_reset();
        // First shot carries the ball toward the corner, second one hits it.
        for (int s = 0; s < 2; s++) begin
            launch(-300, -300);
            prev_x = whiteBallTopLeftX; prev_y = whiteBallTopLeftY;
            bx = 0; by = 0; guard = 0;
            while (m_mode == 2 && guard < 600) begin
                frame(3);
                guard++;
                if (int'(whiteBallTopLeftX) > prev_x) bx = 1;
                if (int'(whiteBallTopLeftY) > prev_y) by = 1;
                prev_x = whiteBallTopLeftX; prev_y = whiteBallTopLeftY;
                total++;
                if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving} !== {11'(m_px / 64), 11'(m_py / 64), m_moving[0]}
                    || whiteBallTopLeftX < 11'd32 || whiteBallTopLeftY < 11'd32) begin
                    bad++;
                    $display("FAIL diag_track s%0d f%0d: got x=%0d y=%0d mv=%0b, want %0d %0d %0d (>=32)",
                             s, guard, whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, m_px / 64, m_py / 64, m_moving);
                end
            end
            if (s == 1) begin
                total++;
                if (bx != 1 || by != 1 || guard >= 600) begin
                    bad++;
                    $display("FAIL diag_bounce: got bx=%0d by=%0d frames=%0d, want 1 1 <600", bx, by, guard);
                end
            end
        end
    endtask

    task automatic test_pocket();
        apply_reset();
        launch(400, 300);
        repeat (3) frame(4);
        pocketed = 1'b1; startOfFrame = 1'b1;
        tick();
        pocketed = 1'b0; startOfFrame = 1'b0;
        total++;
        if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving} !== {11'd320, 11'd240, 1'b0}) begin
            bad++;
            $display("FAIL pocket_respawn: got x=%0d y=%0d mv=%0b, want 320 240 0",
                     whiteBallTopLeftX, whiteBallTopLeftY, ball_moving);
        end
        repeat (3) frame(4);
        total++;
        if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving} !== {11'd320, 11'd240, 1'b0}) begin
            bad++;
            $display("FAIL pocket_still: got x=%0d y=%0d mv=%0b, want 320 240 0",
                     whiteBallTopLeftX, whiteBallTopLeftY, ball_moving);
        end
    endtask

    task automatic test_reset_mid_roll();
        apply_reset();
        launch(-450, 200);
        repeat (4) frame(4);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        total++;
        if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, shot_fired} !== {11'd320, 11'd240, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got x=%0d y=%0d mv=%0b sf=%0b, want 320 240 0 0",
                     whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, shot_fired);
        end
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_random();
        int vx, vy, period, shots0, cyc;
        for (int s = 0; s < 8; s++) begin
            vx = int'($urandom_range(0, 1020)) - 510;
            vy = int'($urandom_range(0, 1020)) - 510;
            if (s == 3) begin
                vx = 0; vy = 0;
            end
            period = int'($urandom_range(2, 6));
            shots0 = shot_cnt;
            launch(vx, vy);
            total++;
            if (shot_fired !== m_shot[0] || ball_moving !== m_moving[0]) begin
                bad++;
                $display("FAIL rand_launch s%0d: got sf=%0b mv=%0b, want %0d %0d", s, shot_fired, ball_moving, m_shot, m_moving);
            end
            cyc = 0;
            while (m_mode == 2 && cyc < 4000) begin
                startOfFrame = (cyc % period == 0);
                game_state   = ($urandom_range(0, 499) != 0);
                pocketed     = ($urandom_range(0, 399) == 0);
                velocityX    = $urandom;
                velocityY    = $urandom;
                tick();
                cyc++;
                total++;
                if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, shot_fired} !==
                    {11'(m_px / 64), 11'(m_py / 64), m_moving[0], m_shot[0]}) begin
                    bad++;
                    $display("FAIL rand_roll s%0d c%0d: got x=%0d y=%0d mv=%0b sf=%0b, want %0d %0d %0d %0d",
                             s, cyc, whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, shot_fired,
                             m_px / 64, m_py / 64, m_moving, m_shot);
                end
            end
            startOfFrame = 0; game_state = 1; pocketed = 0;
            total++;
            if (cyc >= 4000 || shot_cnt - shots0 != ((vx == 0 && vy == 0) ? 0 : 1)) begin
                bad++;
                $display("FAIL rand_end s%0d: got cycles=%0d shots=%0d, want <4000 %0d",
                         s, cyc, shot_cnt - shots0, (vx == 0 && vy == 0) ? 0 : 1);
            end
            frame(period);
            total++;
            if ({whiteBallTopLeftX, whiteBallTopLeftY, ball_moving} !== {11'(m_px / 64), 11'(m_py / 64), 1'b0}) begin
                bad++;
                $display("FAIL rand_rest s%0d: got x=%0d y=%0d mv=%0b, want %0d %0d 0",
                         s, whiteBallTopLeftX, whiteBallTopLeftY, ball_moving, m_px / 64, m_py / 64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shot_x();
        test_stop();
        test_right_cushion();
        test_diagonal();
        test_pocket();
        test_reset_mid_roll();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
